// File: rtl/wb_mem_responder.sv
// wb_mem_responder
//   Wishbone B4 classic/burst slave answering an instruction or data bus from
//   a local word-addressed memory of 2^DEPTH_LOG2 32-bit words starting at
//   word address BASE_ADR. It supports programmable wait states before the
//   first ACK, byte-lane writes, linear incrementing bursts, and ERR for
//   out-of-range addresses.
//
// Parameters
//   DEPTH_LOG2   memory holds 2^DEPTH_LOG2 words
//   BASE_ADR     word address of memory word 0
//   WAIT_STATES  extra cycles (0..15) before the first ACK of a cycle
//
// Ports
//   clock        system clock, rising edge
//   resetn       synchronous active-low reset
//   wb_ADR       word address
//   wb_DAT_MOSI  write data
//   wb_SEL       byte lane enables (bit i -> bits 8i+7:8i)
//   wb_CYC/STB/WE  cycle, strobe, write enable
//   wb_CTI       cycle type (000 classic, 010 incrementing, 111 end)
//   wb_BTE       burst type, only 00 (linear) is bursted
//   hold         back-pressure: no ACK/ERR and wait counter frozen while high
//   wb_DAT_MISO  registered read data, zero outside ACK
//   wb_ACK       registered acknowledge
//   wb_ERR       registered error
module wb_mem_responder #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter logic [29:0] BASE_ADR    = 30'h0,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [29:0] wb_ADR,
    input  logic [31:0] wb_DAT_MOSI,
    input  logic [3:0]  wb_SEL,
    input  logic        wb_CYC,
    input  logic        wb_STB,
    input  logic        wb_WE,
    input  logic [2:0]  wb_CTI,
    input  logic [1:0]  wb_BTE,
    input  logic        hold,
    output logic [31:0] wb_DAT_MISO,
    output logic        wb_ACK,
    output logic        wb_ERR
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_RESP = 3'd2;
    localparam logic [2:0] S_ACKD = 3'd3;
    localparam logic [2:0] S_ERRS = 3'd4;

    logic [31:0]           mem [DEPTH];
    logic [2:0]            state, state_nx;
    logic [3:0]            wcnt, wcnt_nx;
    logic [29:0]           badr, badr_nx, next_adr, acc_adr;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic                  ack_nx, err_nx, access;
    logic                  req, burst_go;

    // Range check done one bit wider so BASE_ADR + depth never overflows.
    function automatic logic in_range(input logic [29:0] adr);
        logic [30:0] off;
        off = {1'b0, adr} - {1'b0, BASE_ADR};
        return (adr >= BASE_ADR) && (off < (31'd1 << DEPTH_LOG2));
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] to_index(input logic [29:0] adr);
        return DEPTH_LOG2'(adr - BASE_ADR);
    endfunction

    assign req      = wb_CYC && wb_STB;
    assign burst_go = req && (wb_CTI == 3'b010) && (wb_BTE == 2'b00);
    assign next_adr = badr + 30'd1;
    assign acc_idx  = to_index(acc_adr);

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        badr_nx  = badr;
        ack_nx   = 1'b0;
        err_nx   = 1'b0;
        access   = 1'b0;
        acc_adr  = badr;
        case (state)
            S_IDLE: begin
                if (req) begin
                    badr_nx = wb_ADR;
                    if (!in_range(wb_ADR)) begin
                        state_nx = S_ERRS;
                    end else if (WAIT_STATES == 0) begin
                        state_nx = S_RESP;
                    end else begin
                        wcnt_nx  = 4'(WAIT_STATES);
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!wb_CYC) begin
                    state_nx = S_IDLE;
                end else if (!hold) begin
                    wcnt_nx = wcnt - 4'd1;
                    if (wcnt <= 4'd1) begin
                        state_nx = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (!wb_CYC) begin
                    state_nx = S_IDLE;
                end else if (!hold) begin
                    access   = 1'b1;
                    ack_nx   = 1'b1;
                    state_nx = S_ACKD;
                end
            end
            S_ACKD: begin
                // A continuing in-range beat takes the RESP action in this
                // same edge so that bursts deliver one ACK per cycle; only a
                // held beat parks in RESP.
                if (burst_go) begin
                    badr_nx = next_adr;
                    if (!in_range(next_adr)) begin
                        state_nx = S_ERRS;
                    end else if (hold) begin
                        state_nx = S_RESP;
                    end else begin
                        acc_adr  = next_adr;
                        access   = 1'b1;
                        ack_nx   = 1'b1;
                        state_nx = S_ACKD;
                    end
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_ERRS: begin
                if (!wb_CYC) begin
                    state_nx = S_IDLE;
                end else if (!hold) begin
                    err_nx   = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= S_IDLE;
            wcnt        <= '0;
            badr        <= '0;
            wb_ACK      <= 1'b0;
            wb_ERR      <= 1'b0;
            wb_DAT_MISO <= '0;
        end else begin
            state       <= state_nx;
            wcnt        <= wcnt_nx;
            badr        <= badr_nx;
            wb_ACK      <= ack_nx;
            wb_ERR      <= err_nx;
            wb_DAT_MISO <= (access && !wb_WE) ? mem[acc_idx] : '0;
        end
    end

    // Memory is never cleared; writes are gated off on a reset edge.
    always_ff @(posedge clock) begin
        if (resetn && access && wb_WE) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wb_SEL[i]) begin
                    mem[acc_idx][8*i +: 8] <= wb_DAT_MOSI[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_mem_responder.sv
// tb_wb_mem_responder
//   Self-checking bench for wb_mem_responder. Two responders share clock and
//   reset: instance 0 (16 words at base 0, one wait state) and instance 1
//   (16 words at base 4, no wait states). A behavioural model holds the
//   expected memory image and derives response timing from the rule "ACK
//   follows WAIT_STATES+1 non-held cycles after the request, ERR follows one".
module tb_wb_mem_responder;

    logic        clock = 1'b0;
    logic        resetn;
    logic [1:0]  cyc, stb, we, hold, ack, err;
    logic [29:0] adr  [2];
    logic [31:0] mosi [2];
    logic [31:0] miso [2];
    logic [3:0]  sel  [2];
    logic [2:0]  cti  [2];
    logic [1:0]  bte  [2];

    logic [31:0] ref_mem [2][16];
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    wb_mem_responder #(.DEPTH_LOG2(4), .BASE_ADR(30'h0), .WAIT_STATES(1)) u_ws1 (
        .clock(clock), .resetn(resetn), .wb_ADR(adr[0]), .wb_DAT_MOSI(mosi[0]),
        .wb_SEL(sel[0]), .wb_CYC(cyc[0]), .wb_STB(stb[0]), .wb_WE(we[0]),
        .wb_CTI(cti[0]), .wb_BTE(bte[0]), .hold(hold[0]),
        .wb_DAT_MISO(miso[0]), .wb_ACK(ack[0]), .wb_ERR(err[0])
    );

    wb_mem_responder #(.DEPTH_LOG2(4), .BASE_ADR(30'h4), .WAIT_STATES(0)) u_ws0 (
        .clock(clock), .resetn(resetn), .wb_ADR(adr[1]), .wb_DAT_MOSI(mosi[1]),
        .wb_SEL(sel[1]), .wb_CYC(cyc[1]), .wb_STB(stb[1]), .wb_WE(we[1]),
        .wb_CTI(cti[1]), .wb_BTE(bte[1]), .hold(hold[1]),
        .wb_DAT_MISO(miso[1]), .wb_ACK(ack[1]), .wb_ERR(err[1])
    );

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic int unsigned base_of(input int k);
        return (k == 0) ? 0 : 4;
    endfunction

    function automatic bit in_rng(input int k, input logic [29:0] a);
        int unsigned ai;
        ai = a;
        return (ai >= base_of(k)) && (ai < base_of(k) + 16);
    endfunction

    function automatic int ix_of(input int k, input logic [29:0] a);
        return int'(a) - int'(base_of(k));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic quiet(input int k, input string tag);
        chk({tag, "/ack0"}, ack[k], 0);
        chk({tag, "/err0"}, err[k], 0);
        chk({tag, "/miso0"}, miso[k], 0);
    endtask

    task automatic idle_bus(input int k);
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0; hold[k] = 1'b0;
        cti[k] = 3'b000; bte[k] = 2'b00;
    endtask

    task automatic timeout_chk(input string tag, input bit done);
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL %s/timeout observed=no-response expected=response", tag);
        end
    endtask

    // Classic single transfer; hm bit j-1 holds the bus in cycle c+j.
    task automatic classic(input int k, input logic w, input logic [29:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           input logic [15:0] hm, input string tag);
        bit inr;
        int need, prod, ix;
        bit done;
        inr  = in_rng(k, a);
        need = inr ? ws_of(k) + 1 : 1;
        prod = 0;
        done = 0;
        @(negedge clock);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; mosi[k] = d;
        sel[k] = s; cti[k] = 3'b000; bte[k] = 2'b00; hold[k] = 1'b0;
        for (int j = 1; j <= 40 && !done; j++) begin
            @(negedge clock);
            if (prod == need) begin
                chk({tag, "/ack"}, ack[k], inr);
                chk({tag, "/err"}, err[k], !inr);
                if (inr) begin
                    ix = ix_of(k, a);
                    if (!w) begin
                        chk({tag, "/rdata"}, miso[k], ref_mem[k][ix]);
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            if (s[i]) ref_mem[k][ix][8*i +: 8] = d[8*i +: 8];
                        end
                    end
                end
                idle_bus(k);
                done = 1;
            end else begin
                quiet(k, tag);
                hold[k] = (j <= 16) ? hm[j-1] : 1'b0;
                if (!hold[k]) prod++;
            end
        end
        idle_bus(k);
        timeout_chk(tag, done);
    endtask

    // Read burst of n beats from a0; bt != 00 must degrade to one classic beat.
    task automatic burst(input int k, input logic [29:0] a0, input int n,
                         input logic [1:0] bt, input string tag);
        logic [29:0] cur;
        int next_at, b;
        bit done;
        cur     = a0;
        b       = 0;
        done    = 0;
        next_at = in_rng(k, a0) ? 2 + ws_of(k) : 2;
        @(negedge clock);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b0; adr[k] = a0; mosi[k] = '0;
        sel[k] = 4'hF; bte[k] = bt; hold[k] = 1'b0;
        cti[k] = (n == 1) ? 3'b111 : 3'b010;
        for (int j = 1; j <= 60 && !done; j++) begin
            @(negedge clock);
            if (j == next_at) begin
                if (in_rng(k, cur)) begin
                    chk({tag, "/ack"}, ack[k], 1);
                    chk({tag, "/err"}, err[k], 0);
                    chk({tag, "/rdata"}, miso[k], ref_mem[k][ix_of(k, cur)]);
                    cti[k] = (b == n - 1) ? 3'b111 : 3'b010;
                    if (b == n - 1 || bt != 2'b00) begin
                        @(negedge clock);
                        quiet(k, {tag, "/end"});
                        done = 1;
                    end else begin
                        b++;
                        cur     = cur + 30'd1;
                        next_at = in_rng(k, cur) ? j + 1 : j + 2;
                    end
                end else begin
                    chk({tag, "/ack"}, ack[k], 0);
                    chk({tag, "/err"}, err[k], 1);
                    done = 1;
                end
                if (done) idle_bus(k);
            end else begin
                quiet(k, tag);
            end
        end
        idle_bus(k);
        timeout_chk(tag, done);
    endtask

    initial begin
        resetn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            idle_bus(k);
            adr[k] = '0; mosi[k] = '0; sel[k] = '0;
        end
        repeat (3) @(negedge clock);
        for (int k = 0; k < 2; k++) quiet(k, "reset");
        resetn = 1'b1;
        @(negedge clock);

        // Preload both memories so the model image is fully known.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                classic(k, 1'b1, 30'(base_of(k) + i), $urandom, 4'hF, 16'h0, "preload");
            end
        end

        classic(0, 1'b1, 30'd5, 32'hDEADBEEF, 4'hF, 16'h0, "wr5");
        classic(0, 1'b0, 30'd5, 32'h0, 4'hF, 16'h0, "rd5");
        classic(0, 1'b1, 30'd7, 32'h11223344, 4'hF, 16'h0, "wr7_full");
        classic(0, 1'b1, 30'd7, 32'hAABBCCDD, 4'b0101, 16'h0, "wr7_lanes");
        classic(0, 1'b0, 30'd7, 32'h0, 4'hF, 16'h0, "rd7_lanes");
        classic(0, 1'b1, 30'd3, 32'h55667788, 4'b0000, 16'h0, "wr3_nosel");
        classic(0, 1'b0, 30'd3, 32'h0, 4'hF, 16'h0, "rd3_nosel");

        for (int i = 0; i < 4; i++) begin
            classic(1, 1'b1, 30'(8 + i), 32'(i + 1), 4'hF, 16'h0, "burst_preload");
        end
        burst(1, 30'd8, 4, 2'b00, "burst8");
        burst(1, 30'd8, 4, 2'b01, "burst_bte01");

        classic(0, 1'b0, 30'd16, 32'h0, 4'hF, 16'h0, "oor16");
        burst(0, 30'd15, 3, 2'b00, "burst15");
        classic(1, 1'b0, 30'd3, 32'h0, 4'hF, 16'h0, "below_base");
        classic(1, 1'b0, 30'd20, 32'h0, 4'hF, 16'h0, "above_top");
        classic(1, 1'b0, 30'd4, 32'h0, 4'hF, 16'h0, "first_word");
        classic(1, 1'b0, 30'd19, 32'h0, 4'hF, 16'h0, "last_word");

        classic(0, 1'b0, 30'd5, 32'h0, 4'hF, 16'h0007, "hold3");
        classic(1, 1'b0, 30'd40, 32'h0, 4'hF, 16'h0003, "hold_err");

        // Abort: CYC dropped while in WAIT.
        @(negedge clock);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 30'd9;
        mosi[0] = 32'hCAFEF00D; sel[0] = 4'hF; cti[0] = 3'b000;
        @(negedge clock);
        quiet(0, "abort");
        idle_bus(0);
        repeat (4) begin
            @(negedge clock);
            quiet(0, "abort_after");
        end
        classic(0, 1'b0, 30'd9, 32'h0, 4'hF, 16'h0, "abort_rd");

        // Reset asserted while the write sits in RESP.
        @(negedge clock);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 30'd10;
        mosi[0] = 32'h0BADF00D; sel[0] = 4'hF; cti[0] = 3'b000;
        @(negedge clock);
        quiet(0, "rst_mid_c1");
        @(negedge clock);
        quiet(0, "rst_mid_c2");
        resetn = 1'b0;
        @(negedge clock);
        quiet(0, "rst_mid_out");
        resetn = 1'b1;
        idle_bus(0);
        @(negedge clock);
        classic(0, 1'b0, 30'd10, 32'h0, 4'hF, 16'h0, "rst_mid_rd");

        for (int r = 0; r < 80; r++) begin
            if ($urandom_range(0, 4) == 0) begin
                burst(int'($urandom_range(0, 1)), 30'($urandom_range(0, 21)),
                      int'($urandom_range(1, 4)), 2'b00, "rnd_burst");
            end else begin
                classic(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        30'($urandom_range(0, 21)), $urandom, 4'($urandom_range(0, 15)),
                        16'($urandom) & 16'h0F0F, "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
